// File: rtl/display_scan_driver.sv
// display_scan_driver: multiplexed 4-digit hex display scanner.
// Each digit is enabled for SCAN_DIV clocks in turn (digit 0..3). A new
// 16-bit value is parked in a single-entry pending slot and copied to the
// shown value only at a frame boundary (leaving digit 3 for digit 0), so a
// frame never mixes digits of two different values.
// Optional feature: define DISPLAY_SCAN_LEADING_ZERO_BLANK_EN to suppress
// leading zero digits (digit 0 is always shown).
module display_scan_driver #(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    output logic [3:0]  digit_nibble,
    output logic [3:0]  digit_an,
    output logic        digit_blank,
    output logic        frame_done
);

    localparam logic [15:0] TICK_COUNT = 16'(SCAN_DIV - 1);

    logic [15:0] presc_q, presc_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] display_q, display_d;
    logic [15:0] pending_q, pending_d;
    logic        pending_full_q, pending_full_d;
    logic [3:0]  an_q, an_d;
    logic [3:0]  nibble_q, nibble_d;
    logic        blank_q, blank_d;
    logic        frame_done_q, frame_done_d;

    logic tick;
    logic boundary;
    logic accept;

    assign tick       = (presc_q == TICK_COUNT);
    assign boundary   = tick && (idx_q == 2'd3);
    assign accept     = load_valid && !pending_full_q;
    assign load_ready = !pending_full_q;

    // Prescaler, scan index and the pending/display double buffer.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        presc_d        = tick ? 16'd0 : presc_q + 16'd1;
        idx_d          = tick ? idx_q + 2'd1 : idx_q;
        display_d      = display_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        if (boundary && pending_full_q) begin
            display_d      = pending_q;
            pending_full_d = 1'b0;
        end else if (accept) begin
            pending_d      = load_data;
            pending_full_d = 1'b1;
        end
    end

    // Digit outputs for the index being entered; they change only on a tick.
    always_comb begin
        an_d         = an_q;
        nibble_d     = nibble_q;
        blank_d      = blank_q;
        frame_done_d = boundary;
        if (tick) begin
            an_d     = ~(4'b0001 << idx_d);
            nibble_d = display_d[{idx_d, 2'b00} +: 4];
`ifdef DISPLAY_SCAN_LEADING_ZERO_BLANK_EN
            // Digit k>0 is a leading zero when digits k..3 are all zero.
            if ((idx_d != 2'd0) && ((display_d >> {idx_d, 2'b00}) == 16'h0000)) begin
                blank_d = 1'b1;
                an_d    = 4'b1111;
            end else begin
                blank_d = 1'b0;
            end
`else
            blank_d = 1'b0;
`endif
        end
    end

    // Control and output registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q        <= 16'd0;
            idx_q          <= 2'd0;
            display_q      <= 16'h0000;
            pending_full_q <= 1'b0;
            an_q           <= 4'b1110;
            nibble_q       <= 4'h0;
            blank_q        <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            presc_q        <= presc_d;
            idx_q          <= idx_d;
            display_q      <= display_d;
            pending_full_q <= pending_full_d;
            an_q           <= an_d;
            nibble_q       <= nibble_d;
            blank_q        <= blank_d;
            frame_done_q   <= frame_done_d;
        end
    end

    // Pending data word; its contents only matter while pending_full_q is set.
    always_ff @(posedge clk) begin
        // NOTE: pure data storage is left without reset; the valid flag
        // pending_full_q is reset and qualifies it.
        pending_q <= pending_d;
    end

    assign digit_an     = an_q;
    assign digit_nibble = nibble_q;
    assign digit_blank  = blank_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Self-checking bench for display_scan_driver (SCAN_DIV = 4).
// The reference model tracks n = clock edges since reset release; the active
// digit is (n / SCAN_DIV) % 4, a frame boundary edge leaves state n where
// n % (4*SCAN_DIV) == 4*SCAN_DIV-1, and the pending slot is a valid/value pair.
module tb_display_scan_driver;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = 16'h0000;
    logic        load_ready;
    logic [3:0]  digit_nibble;
    logic [3:0]  digit_an;
    logic        digit_blank;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    display_scan_driver #(.SCAN_DIV(S)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_ready   (load_ready),
        .digit_nibble (digit_nibble),
        .digit_an     (digit_an),
        .digit_blank  (digit_blank),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_n      = 0;
    logic [15:0] m_disp   = 16'h0000;
    logic [15:0] m_pend   = 16'h0000;
    bit          m_pend_v = 1'b0;
    bit          m_frame_end;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n      = 0;
            m_disp   = 16'h0000;
            m_pend_v = 1'b0;
        end else begin
            m_frame_end = (m_n % (4 * S)) == (4 * S - 1);
            if (m_frame_end && m_pend_v) begin
                m_disp   = m_pend;
                m_pend_v = 1'b0;
            end else if (load_valid && !m_pend_v) begin
                m_pend   = load_data;
                m_pend_v = 1'b1;
            end
            m_n = m_n + 1;
        end
    end

    function automatic logic [3:0] digit_of(input logic [15:0] v, input int k);
        return v[4*k +: 4];
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h (t=%0t, n=%0d)", name, act, exp, $time, m_n);
        end
    endtask

    // ---------------- per-cycle compare against the model ----------------
    int       c_k;
    bit       c_upper_zero;
    bit       c_blank;
    bit       c_fd;
    logic [3:0] c_an;

    always @(negedge clk) begin
        if (rst_n) begin
            c_k = (m_n / S) % 4;
            c_upper_zero = 1'b1;
            for (int j = c_k; j < 4; j++)
                if (digit_of(m_disp, j) != 4'h0) c_upper_zero = 1'b0;
            c_blank = 1'b0;
`ifdef DISPLAY_SCAN_LEADING_ZERO_BLANK_EN
            c_blank = (c_k != 0) && c_upper_zero;
`endif
            c_an = 4'b1111;
            if (!c_blank) c_an[c_k] = 1'b0;
            c_fd = (m_n > 0) && ((m_n % (4 * S)) == 0);
            check("model digit_an",     16'(digit_an),     16'(c_an));
            check("model digit_nibble", 16'(digit_nibble), 16'(digit_of(m_disp, c_k)));
            check("model digit_blank",  16'(digit_blank),  16'(c_blank));
            check("model frame_done",   16'(frame_done),   16'(c_fd));
            check("model load_ready",   16'(load_ready),   16'(!m_pend_v));
        end
    end

    // Advance to the negedge where the model is at state n = target.
    task automatic wait_to(input int target);
        int guard;
        guard = 0;
        while (m_n < target && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (m_n != target) begin
            bad++;
            $display("FAIL wait_to: reached n=%0d, required n=%0d", m_n, target);
        end
    endtask

    logic [15:0] masks [5] = '{16'hFFFF, 16'h00FF, 16'h000F, 16'h0000, 16'h0FFF};

    // ---------------- stimulus and literal expectations ----------------
    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("reset digit_an",     16'(digit_an),     16'h000E);
        check("reset digit_nibble", 16'(digit_nibble), 16'h0000);
        check("reset load_ready",   16'(load_ready),   16'h0001);
        check("reset frame_done",   16'(frame_done),   16'h0000);
        #2 rst_n = 1'b1;

        // Scan sequence with SCAN_DIV=4: each digit held 4 cycles, frame every 16.
        wait_to(4);  check("scan an n4",  16'(digit_an), 16'h000D);
        wait_to(7);  check("scan an n7",  16'(digit_an), 16'h000D);
        wait_to(8);  check("scan an n8",  16'(digit_an), 16'h000B);
        wait_to(12); check("scan an n12", 16'(digit_an), 16'h0007);
        wait_to(15); check("scan fd n15", 16'(frame_done), 16'h0000);
        wait_to(16); check("scan an n16", 16'(digit_an), 16'h000E);
                     check("scan fd n16", 16'(frame_done), 16'h0001);
        wait_to(17); check("scan fd n17", 16'(frame_done), 16'h0000);
        wait_to(32); check("scan fd n32", 16'(frame_done), 16'h0001);

        // Mid-frame load of 1A2F: held in pending until the boundary.
        wait_to(33); load_valid = 1'b1; load_data = 16'h1A2F;
        wait_to(34); check("1A2F ready low", 16'(load_ready), 16'h0000);
                     load_valid = 1'b0; load_data = 16'(($urandom));
        wait_to(47); check("1A2F no tearing", 16'(digit_nibble), 16'h0000);
        wait_to(48); check("1A2F digit0", 16'(digit_nibble), 16'h000F);
                     check("1A2F ready back", 16'(load_ready), 16'h0001);
        wait_to(52); check("1A2F digit1", 16'(digit_nibble), 16'h0002);
        wait_to(56); check("1A2F digit2", 16'(digit_nibble), 16'h000A);
        wait_to(60); check("1A2F digit3", 16'(digit_nibble), 16'h0001);

        // Second value offered while pending is full: taken the cycle after transfer.
        wait_to(61); load_valid = 1'b1; load_data = 16'h5555;
        wait_to(62); check("hold ready n62", 16'(load_ready), 16'h0000);
                     load_data = 16'h7B3C;
        wait_to(63); check("hold ready n63", 16'(load_ready), 16'h0000);
                     check("hold old digit3", 16'(digit_nibble), 16'h0001);
        wait_to(64); check("hold ready n64", 16'(load_ready), 16'h0001);
                     check("5555 digit0", 16'(digit_nibble), 16'h0005);
        wait_to(65); check("7B3C accepted", 16'(load_ready), 16'h0000);
                     load_valid = 1'b0;
        wait_to(80); check("7B3C digit0", 16'(digit_nibble), 16'h000C);
        wait_to(92); check("7B3C digit3", 16'(digit_nibble), 16'h0007);

        // Leading-zero value 0030.
        wait_to(93); load_valid = 1'b1; load_data = 16'h0030;
        wait_to(94); load_valid = 1'b0;
        wait_to(96);  check("0030 d0 nibble", 16'(digit_nibble), 16'h0000);
                      check("0030 d0 an",     16'(digit_an),     16'h000E);
                      check("0030 d0 blank",  16'(digit_blank),  16'h0000);
        wait_to(100); check("0030 d1 nibble", 16'(digit_nibble), 16'h0003);
                      check("0030 d1 an",     16'(digit_an),     16'h000D);
        wait_to(104); check("0030 d2 nibble", 16'(digit_nibble), 16'h0000);
`ifdef DISPLAY_SCAN_LEADING_ZERO_BLANK_EN
                      check("0030 d2 blank", 16'(digit_blank), 16'h0001);
                      check("0030 d2 an",    16'(digit_an),    16'h000F);
        wait_to(108); check("0030 d3 blank", 16'(digit_blank), 16'h0001);
                      check("0030 d3 an",    16'(digit_an),    16'h000F);
`else
                      check("0030 d2 blank", 16'(digit_blank), 16'h0000);
                      check("0030 d2 an",    16'(digit_an),    16'h000B);
        wait_to(108); check("0030 d3 blank", 16'(digit_blank), 16'h0000);
                      check("0030 d3 an",    16'(digit_an),    16'h0007);
`endif

        // Reset mid-frame with pending full.
        wait_to(109); load_valid = 1'b1; load_data = 16'hBEEF;
        wait_to(110); load_valid = 1'b0;
                      check("BEEF pending", 16'(load_ready), 16'h0000);
        wait_to(111);
        #2 rst_n = 1'b0;
        #1;
        check("async rst an",     16'(digit_an),     16'h000E);
        check("async rst nibble", 16'(digit_nibble), 16'h0000);
        check("async rst blank",  16'(digit_blank),  16'h0000);
        check("async rst fd",     16'(frame_done),   16'h0000);
        check("async rst ready",  16'(load_ready),   16'h0001);
        repeat (2) @(negedge clk);
        check("in rst ready", 16'(load_ready), 16'h0001);
        #2 rst_n = 1'b1;
        wait_to(16); check("post rst fd",     16'(frame_done),   16'h0001);
                     check("post rst digit0", 16'(digit_nibble), 16'h0000);

        // Randomized traffic, with one reset pulse part-way through.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            load_valid = ($urandom_range(0, 7) == 0);
            load_data  = 16'($urandom) & masks[$urandom_range(0, 4)];
            if (i == 1500) begin
                #2 rst_n = 1'b0;
                #3 rst_n = 1'b1;
            end
        end
        load_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
